// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the boot ROM and feeds decode through an in-order prefetch FIFO.
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirects yield one flagged NOP entry, then fetch halts.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] instr_rd_addr,
    output logic        instr_rd_en,
    input  logic [31:0] instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr,
    output logic        fetch_misalign
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);

`ifdef FETCH_MISALIGN_CHK_EN
    typedef enum logic [2:0] {S_BOOT, S_RUN, S_FLUSH, S_MISAL, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;
`endif

    state_t             state, state_nxt;
    logic [31:0]        pc, pc_q, fetch_addr;
    logic               inflight, squash;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [31:0]        mem_pc    [FIFO_DEPTH];
    logic [31:0]        mem_instr [FIFO_DEPTH];
    logic [CNT_W:0]     occupancy;
    logic               pop, push, issue, credit_ok, issue_state;
    logic [31:0]        push_instr;
`ifdef FETCH_MISALIGN_CHK_EN
    logic               mem_mis [FIFO_DEPTH];
    logic               push_fake, redirect_mis;
`endif

    always_comb begin
        fetch_addr  = {pc[31:2], 2'b00};
        fetch_valid = (count != '0) && !redirect_valid;
        pop         = fetch_valid && fetch_ready;
        // Outstanding read counts against capacity so a response always has a free slot.
        occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
        credit_ok   = occupancy < DEPTH_W;
        issue_state = (state == S_RUN) || (state == S_FLUSH);
        issue       = issue_state && credit_ok && !redirect_valid;
        push        = inflight && !squash && !redirect_valid;
        push_instr  = instr;
`ifdef FETCH_MISALIGN_CHK_EN
        redirect_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
        push_fake    = (state == S_MISAL) && !redirect_valid;
        if (push_fake) begin
            push       = 1'b1;
            push_instr = 32'h0000_0013;
        end
`endif
        instr_rd_en   = issue;
        instr_rd_addr = issue ? fetch_addr : '0;
        fetch_pc      = fetch_valid ? mem_pc[rd_ptr]    : '0;
        fetch_instr   = fetch_valid ? mem_instr[rd_ptr] : '0;
`ifdef FETCH_MISALIGN_CHK_EN
        fetch_misalign = fetch_valid && mem_mis[rd_ptr];
`else
        fetch_misalign = 1'b0;
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:  state_nxt = S_RUN;
            S_RUN:   state_nxt = redirect_valid ? S_FLUSH : S_RUN;
            S_FLUSH: state_nxt = redirect_valid ? S_FLUSH : S_RUN;
`ifdef FETCH_MISALIGN_CHK_EN
            S_MISAL: state_nxt = redirect_valid ? S_FLUSH : S_HALT;
            S_HALT:  state_nxt = redirect_valid ? S_FLUSH : S_HALT;
`endif
            default: state_nxt = S_BOOT;
        endcase
`ifdef FETCH_MISALIGN_CHK_EN
        if (state != S_BOOT && redirect_mis)
            state_nxt = S_MISAL;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_BOOT;
            pc       <= RESET_VECTOR;
            pc_q     <= '0;
            inflight <= 1'b0;
            squash   <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            squash   <= redirect_valid;
            if (redirect_valid)
                pc <= redirect_pc;
            else if (issue)
                pc <= pc + 32'd4;
            if (issue)
                pc_q <= fetch_addr;
`ifdef FETCH_MISALIGN_CHK_EN
            else if (redirect_mis)
                pc_q <= redirect_pc;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !redirect_valid) begin
            mem_pc[wr_ptr]    <= pc_q;
            mem_instr[wr_ptr] <= push_instr;
`ifdef FETCH_MISALIGN_CHK_EN
            mem_mis[wr_ptr]   <= push_fake;
`endif
        end
    end

endmodule
